data_mem_responder: RTL and testbench

- Responder side of the load/store interface driven by the MEM stage.
- Accepts one read or write request at a time over a valid/ready handshake and writes a word-organised data array with byte enables.
- Returns a single-cycle response pulse after a parameterised read latency and flags misaligned or out-of-range accesses.
- The MEM stage stalls on busy; branch resolution is unaffected.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 38 +++
 rtl/data_mem_responder.sv | 97 +++++++++
 tb/tb_data_mem_responder.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int LANE_W = 8;

  // Read latency is held in a small down-counter, so only 1..4 is supported.
  function automatic bit read_lat_ok(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request/response bus between MEM stage and responder
interface data_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_byte_en;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byte_en,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_en,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array, byte-masked write, one-cycle registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [DATA_W/LANE_W-1:0]   be_i,
  input  logic [DEPTH_LOG2-1:0]      addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data is only updated by a read, so it holds steady through the wait states.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < LANES; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - one-outstanding load/store responder with fixed read latency
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus
);
  localparam int CNT_W = 3;

  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("data_mem_responder: READ_LAT must be in 1..4");
  end

  dmem_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;
  logic                 rd_q;

  logic                 accept;
  logic                 addr_err;
  logic                 arr_en;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DATA_W-1:0]    arr_rdata;

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign word_idx = bus.req_addr[DEPTH_LOG2:1];
  assign addr_err = bus.req_addr[0] || ((bus.req_addr >> (DEPTH_LOG2 + 1)) != '0);
  // Gated by rst_n so a request held during reset cannot touch the array.
  assign arr_en   = accept && !addr_err && rst_n;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en),
    .we_i    (bus.req_write),
    .be_i    (bus.req_byte_en),
    .addr_i  (word_idx),
    .wdata_i (bus.req_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            err_q <= addr_err;
            rd_q  <= !bus.req_write && !addr_err;
            if (!bus.req_write && !addr_err && (READ_LAT > 1)) begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(READ_LAT - 1);
            end else begin
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rd_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && rd_q) ? arr_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench over four read latencies
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_byte_en;
  logic [1:0]  sel;

  logic [3:0]  rdy_v, val_v, err_v, busy_v;
  logic [15:0] rd_v [4];

  logic        o_ready, o_valid, o_err, o_busy;
  logic [15:0] o_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance g has READ_LAT 2, 3, 1, 4 for g = 0..3; sel routes stimulus and observation.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;
    data_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    assign bus.req_valid   = req_valid && (sel == 2'(g));
    assign bus.req_write   = req_write;
    assign bus.req_addr    = req_addr;
    assign bus.req_wdata   = req_wdata;
    assign bus.req_byte_en = req_byte_en;
    data_mem_responder #(
      .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .READ_LAT(LAT)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign rdy_v[g]  = bus.req_ready;
    assign val_v[g]  = bus.resp_valid;
    assign err_v[g]  = bus.resp_err;
    assign busy_v[g] = bus.busy;
    assign rd_v[g]   = bus.resp_rdata;
  end

  assign o_ready = rdy_v[sel];
  assign o_valid = val_v[sel];
  assign o_err   = err_v[sel];
  assign o_busy  = busy_v[sel];
  assign o_rdata = rd_v[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a sample point with the selected instance idle; returns at a sample point, idle.
  task automatic do_req(input string tag, input logic [1:0] s, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                        input int exp_lat, input logic [15:0] exp_rd, input logic exp_err);
    int cyc;
    sel = s; req_write = wr; req_addr = a; req_wdata = wd; req_byte_en = be;
    req_valid = 1'b1;
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    cyc = 1;
    while (!o_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_rdata"}, 32'(o_rdata), 32'(exp_rd));
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "_pulse"}, {o_valid, o_err, o_rdata}, 32'd0);
    check({tag, "_idle"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ready_pat, resp_pat;
    int          pulses;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_byte_en = '0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_resp", {o_valid, o_err, o_rdata}, 32'd0);

    do_req("wr_beef",  2'd0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1, 16'h0000, 1'b0);
    do_req("rd_beef",  2'd0, 1'b0, 16'h0010, 16'h0000, 2'b00, 2, 16'hBEEF, 1'b0);

    do_req("wr_1234",  2'd0, 1'b1, 16'h0020, 16'h1234, 2'b11, 1, 16'h0000, 1'b0);
    do_req("wr_hi",    2'd0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 1, 16'h0000, 1'b0);
    do_req("rd_ab34",  2'd0, 1'b0, 16'h0020, 16'hFFFF, 2'b01, 2, 16'hAB34, 1'b0);
    do_req("wr_be00",  2'd0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 1, 16'h0000, 1'b0);
    do_req("rd_keep",  2'd0, 1'b0, 16'h0020, 16'h0000, 2'b00, 2, 16'hAB34, 1'b0);

    do_req("rd_mis",   2'd0, 1'b0, 16'h0011, 16'h0000, 2'b00, 1, 16'h0000, 1'b1);
    do_req("wr_w0",    2'd0, 1'b1, 16'h0000, 16'h5A5A, 2'b11, 1, 16'h0000, 1'b0);
    do_req("wr_oor",   2'd0, 1'b1, 16'h0200, 16'h1111, 2'b11, 1, 16'h0000, 1'b1);
    do_req("rd_w0",    2'd0, 1'b0, 16'h0000, 16'h0000, 2'b00, 2, 16'h5A5A, 1'b0);

    // Continuous requests into the READ_LAT=3 instance.
    do_req("wr_hs",    2'd1, 1'b1, 16'h0030, 16'h0303, 2'b11, 1, 16'h0000, 1'b0);
    sel = 2'd1; req_write = 1'b0; req_addr = 16'h0030; req_byte_en = 2'b00;
    req_valid = 1'b1;
    ready_pat = '0; resp_pat = '0;
    for (int i = 0; i < 16; i++) begin
      ready_pat[i] = o_ready;
      resp_pat[i]  = o_valid;
      if (o_valid) check("hs_rdata", 32'(o_rdata), 32'h0303);
      if (i == 15) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("hs_ready_pat", 32'(ready_pat), 32'h1111);
    check("hs_resp_pat", 32'(resp_pat), 32'h8888);
    check("hs_idle", 32'(o_ready), 32'd1);

    // Reset in the cycle after a read accept drops the response.
    sel = 2'd0; req_write = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_ready", 32'(o_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_valid) pulses++;
      @(posedge clk); #1;
    end
    check("rstmid_nopulse", 32'(pulses), 32'd0);
    do_req("rstmid_rd", 2'd0, 1'b0, 16'h0010, 16'h0000, 2'b00, 2, 16'hBEEF, 1'b0);

    do_req("l1_wr",    2'd2, 1'b1, 16'h0040, 16'hC0DE, 2'b11, 1, 16'h0000, 1'b0);
    do_req("l1_rd",    2'd2, 1'b0, 16'h0040, 16'h0000, 2'b00, 1, 16'hC0DE, 1'b0);
    do_req("l4_wr",    2'd3, 1'b1, 16'h0040, 16'h4444, 2'b11, 1, 16'h0000, 1'b0);
    do_req("l4_rd",    2'd3, 1'b0, 16'h0040, 16'h0000, 2'b00, 4, 16'h4444, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
